// File: rtl/image_pipe_pkg.sv
// Shared types and constants for image pipe filter stages.
// Filter arithmetic uses a [1 2 1]/4 kernel with round-half-up.
package image_pipe_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   localparam int RND = 2;
   localparam int SH  = 2;

   // Two extra bits hold a + 2b + c + RND without overflow.
   function automatic int sum_w(input int dw);
      return dw + 2;
   endfunction

endpackage

// File: rtl/image_pipe_tap3.sv
// Combinational 3-tap [1 2 1]/4 kernel with rounding: y = (a + 2b + c + 2) >> 2.
// Shared by horizontal and future vertical filter stages.
module image_pipe_tap3
   import image_pipe_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   output logic [DW-1:0] y
);

   localparam int SW = sum_w(DW);

   logic [SW-1:0] sum;

   assign sum = SW'(a) + (SW'(b) << 1) + SW'(c) + SW'(RND);
   // All-ones inputs round back to all-ones, so the top DW bits never overflow.
   assign y   = sum[SH +: DW];

endmodule

// File: rtl/image_pipe_hfilter.sv
// Horizontal [1 2 1]/4 smoothing stage with edge replication on the image pipe stream.
// Also counts completed output lines.
module image_pipe_hfilter
   import image_pipe_pkg::*;
#(
   parameter int DW  = 32,
   parameter int LCW = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [DW-1:0]  is_data_in,
   input  logic           is_valid_in,
   input  logic           is_end_in,
   output logic           is_busy_out,
   output logic [DW-1:0]  im_data_out,
   output logic           im_valid_out,
   output logic           im_end_out,
   input  logic           im_busy_in,
   output logic [LCW-1:0] line_cnt
);

   // Handshake: a transfer happens on a rising edge where valid=1 and busy=0;
   // while valid=1 and busy=1 the sender holds data and end stable.

   state_e          state, state_nxt;
   logic [DW-1:0]   prev, cur;
   logic [DW-1:0]   tap_c, tap_y;
   logic            out_free;
   logic            emit, emit_end;
   logic            load_first, shift_in;

   assign out_free = !im_valid_out || !im_busy_in;

   // The flush pixel replicates cur as its right neighbour.
   assign tap_c = (state == S_FLUSH) ? cur : is_data_in;

   image_pipe_tap3 #(.DW(DW)) u_tap3 (
      .a (prev),
      .b (cur),
      .c (tap_c),
      .y (tap_y)
   );

   always_comb begin
      state_nxt   = state;
      is_busy_out = 1'b0;
      emit        = 1'b0;
      emit_end    = 1'b0;
      load_first  = 1'b0;
      shift_in    = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_valid_in) begin
               load_first = 1'b1;
               state_nxt  = is_end_in ? S_FLUSH : S_RUN;
            end
         end
         S_RUN: begin
            is_busy_out = !out_free;
            if (is_valid_in && out_free) begin
               emit      = 1'b1;
               shift_in  = 1'b1;
               state_nxt = is_end_in ? S_FLUSH : S_RUN;
            end
         end
         S_FLUSH: begin
            is_busy_out = 1'b1;
            if (out_free) begin
               emit      = 1'b1;
               emit_end  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         prev  <= '0;
         cur   <= '0;
      end else begin
         state <= state_nxt;
         if (load_first) begin
            prev <= is_data_in;
            cur  <= is_data_in;
         end else if (shift_in) begin
            prev <= cur;
            cur  <= is_data_in;
         end
      end
   end

   // Output register reloads on the same edge its previous contents are taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im_data_out  <= '0;
         im_end_out   <= 1'b0;
         im_valid_out <= 1'b0;
         line_cnt     <= '0;
      end else begin
         if (emit) begin
            im_data_out  <= tap_y;
            im_end_out   <= emit_end;
            im_valid_out <= 1'b1;
         end else if (!im_busy_in) begin
            im_valid_out <= 1'b0;
         end
         if (emit_end) line_cnt <= line_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_image_pipe_hfilter.sv
// Scoreboard bench for image_pipe_hfilter: a line-level reference model fills
// an expected queue; a monitor pops on every accepted output.
module tb_image_pipe_hfilter;

   localparam int DW  = 8;
   localparam int LCW = 16;

   // clock / reset
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0]  is_data_in = '0;
   logic           is_valid_in = 1'b0;
   logic           is_end_in = 1'b0;
   logic           is_busy_out;
   logic [DW-1:0]  im_data_out;
   logic           im_valid_out;
   logic           im_end_out;
   logic           im_busy_in = 1'b0;
   logic [LCW-1:0] line_cnt;

   image_pipe_hfilter #(.DW(DW), .LCW(LCW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .is_data_in   (is_data_in),
      .is_valid_in  (is_valid_in),
      .is_end_in    (is_end_in),
      .is_busy_out  (is_busy_out),
      .im_data_out  (im_data_out),
      .im_valid_out (im_valid_out),
      .im_end_out   (im_end_out),
      .im_busy_in   (im_busy_in),
      .line_cnt     (line_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard: {end, data}
   logic [DW:0] exp_q[$];
   int          exp_lines = 0;
   int          line_px[64];
   int          busy_mode = 0;   // 0: never busy, 1: random, 2: manual

   always @(posedge clk) begin
      #1;
      if (busy_mode == 1) im_busy_in = 1'($urandom_range(0, 1));
      else if (busy_mode == 0) im_busy_in = 1'b0;
   end

   // Reference model: whole-line [1 2 1]/4 with clamped neighbours.
   task automatic push_line(input int n);
      for (int i = 0; i < n; i++) begin
         int a, b, c, y;
         a = line_px[(i == 0) ? 0 : i - 1];
         b = line_px[i];
         c = line_px[(i == n - 1) ? n - 1 : i + 1];
         y = (a + 2 * b + c + 2) / 4;
         exp_q.push_back({(i == n - 1), y[DW-1:0]});
      end
   endtask

   // monitor
   logic          hold_seen = 1'b0;
   logic [DW-1:0] hold_data;
   logic          hold_end;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_seen = 1'b0;
      end else begin
         if (hold_seen) begin
            check("hold_valid", 32'(im_valid_out), 32'd1);
            check("hold_data", 32'(im_data_out), 32'(hold_data));
            check("hold_end", 32'(im_end_out), 32'(hold_end));
         end
         hold_seen = im_valid_out && im_busy_in;
         hold_data = im_data_out;
         hold_end  = im_end_out;
         if (im_valid_out && !im_busy_in) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(im_data_out), 32'hFFFF_FFFF);
            end else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               check("out_data", 32'(im_data_out), 32'(e[DW-1:0]));
               check("out_end", 32'(im_end_out), 32'(e[DW]));
               if (e[DW]) begin
                  exp_lines++;
                  check("line_cnt", 32'(line_cnt), 32'(exp_lines[LCW-1:0]));
               end
            end
         end
      end
   end

   // drivers
   task automatic drive_px(input logic [DW-1:0] d, input logic e);
      int waitc = 0;
      logic acc;
      is_data_in  = d;
      is_end_in   = e;
      is_valid_in = 1'b1;
      forever begin
         @(negedge clk);
         acc = !is_busy_out;
         @(posedge clk);
         #1;
         if (acc) break;
         waitc++;
         if (waitc > 200) begin
            check("accept_timeout", 32'(waitc), 32'd0);
            break;
         end
      end
      is_valid_in = 1'b0;
      is_end_in   = 1'b0;
   endtask

   task automatic idle_cycle();
      is_valid_in = 1'b0;
      is_end_in   = 1'($urandom_range(0, 1));
      is_data_in  = DW'($urandom);
      @(posedge clk);
      #1;
      is_end_in = 1'b0;
   endtask

   task automatic send_line(input int n, input int max_gap);
      push_line(n);
      for (int i = 0; i < n; i++) begin
         int g;
         g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         for (int k = 0; k < g; k++) idle_cycle();
         drive_px(DW'(line_px[i]), (i == n - 1));
      end
   endtask

   task automatic drain();
      int c = 0;
      while ((exp_q.size() != 0 || im_valid_out) && c < 500) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic set4(input int a, input int b, input int c, input int d);
      line_px[0] = a; line_px[1] = b; line_px[2] = c; line_px[3] = d;
   endtask

   initial begin
      #3;
      check("rst_valid", 32'(im_valid_out), 32'd0);
      check("rst_end", 32'(im_end_out), 32'd0);
      check("rst_data", 32'(im_data_out), 32'd0);
      check("rst_line_cnt", 32'(line_cnt), 32'd0);
      check("rst_busy", 32'(is_busy_out), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 10,20,30,40 -> 13,20,30,38 with a single flush bubble
      busy_mode = 0;
      set4(10, 20, 30, 40);
      send_line(4, 0);
      @(negedge clk);
      check("bubble_busy", 32'(is_busy_out), 32'd1);
      @(negedge clk);
      check("after_bubble", 32'(is_busy_out), 32'd0);
      drain();
      check("lines_1", 32'(line_cnt), 32'd1);

      // single pixel 0xFF
      line_px[0] = 255;
      send_line(1, 0);
      drain();
      check("lines_2", 32'(line_cnt), 32'd2);

      // 0,255 -> 64,191
      line_px[0] = 0; line_px[1] = 255;
      send_line(2, 0);
      drain();

      // downstream stall of 5 cycles on the first output
      busy_mode = 2;
      im_busy_in = 1'b0;
      set4(10, 20, 30, 40);
      fork
         send_line(4, 0);
         begin
            int c = 0;
            do begin
               @(posedge clk);
               #1;
               c++;
            end while (!im_valid_out && c < 50);
            check("stall_wait", 32'(im_valid_out), 32'd1);
            im_busy_in = 1'b1;
            repeat (5) begin
               @(negedge clk);
               check("stall_data", 32'(im_data_out), 32'd13);
               check("stall_busy", 32'(is_busy_out), 32'd1);
               @(posedge clk);
               #1;
            end
            im_busy_in = 1'b0;
         end
      join
      drain();
      busy_mode = 0;

      // back-to-back 5,5,5 then 100,0
      begin
         int base;
         base = exp_lines;
         line_px[0] = 5; line_px[1] = 5; line_px[2] = 5;
         send_line(3, 0);
         line_px[0] = 100; line_px[1] = 0;
         send_line(2, 0);
         drain();
         check("b2b_lines", 32'(line_cnt), 32'(base + 2));
      end

      // randomized lines with random gaps and backpressure
      busy_mode = 1;
      for (int l = 0; l < 30; l++) begin
         int n;
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) line_px[i] = $urandom_range(0, 255);
         send_line(n, 2);
      end
      busy_mode = 0;
      drain();

      // reset mid-line, then single-pixel line 7
      busy_mode = 2;
      im_busy_in = 1'b1;
      drive_px(8'd50, 1'b0);
      drive_px(8'd90, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(im_valid_out), 32'd0);
      check("mid_rst_lines", 32'(line_cnt), 32'd0);
      exp_q.delete();
      exp_lines = 0;
      @(posedge clk);
      #1;
      check("in_rst_valid", 32'(im_valid_out), 32'd0);
      rst_n = 1'b1;
      im_busy_in = 1'b0;
      busy_mode = 0;
      @(posedge clk);
      #1;
      line_px[0] = 7;
      send_line(1, 0);
      drain();
      check("post_rst_lines", 32'(line_cnt), 32'd1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
